// File: rtl/issue_instr_queue_pkg.sv
// Types shared by the id/issue decoupling queue: the decoded scoreboard entry and
// the outstanding-branch state.
package issue_instr_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    exception_t  ex;
  } scoreboard_entry_t;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_PEND = 1'b1
  } br_state_e;

endpackage

// File: rtl/issue_instr_queue.sv
// Decoupling FIFO between decode and issue. Holds back a ctrl-flow head while an
// earlier ctrl-flow instruction is still unresolved in EX.
module issue_instr_queue
  import issue_instr_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              stall_i,
  input  scoreboard_entry_t decoded_instr_i,
  input  logic              decoded_instr_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              decoded_instr_ack_o,
  output scoreboard_entry_t issue_entry_o,
  output logic              issue_entry_valid_o,
  output logic              issue_ctrl_flow_o,
  input  logic              issue_entry_ack_i,
  input  logic              resolve_branch_i,
  output logic              queue_full_o,
  output logic              branch_pending_o,
  output logic [CW-1:0]     occupancy_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              ctrl_flow;
  } slot_t;

  slot_t         mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] occ_q;
  br_state_e     br_q;
  logic          full, empty, push, pop;

  assign full  = (occ_q == CW'(DEPTH));
  assign empty = (occ_q == '0);

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full & ~flush_i;
  assign push                = decoded_instr_ack_o;

  assign issue_entry_o       = mem_q[rd_ptr_q].sbe;
  assign issue_ctrl_flow_o   = mem_q[rd_ptr_q].ctrl_flow;
  assign issue_entry_valid_o = ~empty & ~stall_i & ~flush_i
                             & ~(issue_ctrl_flow_o & (br_q == BR_PEND));
  assign pop                 = issue_entry_valid_o & issue_entry_ack_i;

  assign queue_full_o     = full;
  assign occupancy_o      = occ_q;
  assign branch_pending_o = (br_q == BR_PEND);

  // Payload storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{sbe: decoded_instr_i, ctrl_flow: is_ctrl_flow_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      occ_q <= occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_q <= BR_IDLE;
    end else if (flush_i) begin
      br_q <= BR_IDLE;
    end else begin
      case (br_q)
        BR_IDLE: if (pop && issue_ctrl_flow_o) br_q <= BR_PEND;
        BR_PEND: if (resolve_branch_i)         br_q <= BR_IDLE;
        default:                               br_q <= BR_IDLE;
      endcase
    end
  end

endmodule
